harvard_mem_subsys: RTL and testbench

Parametrised successor to the fixed 1 KB byte-enabled ROM/RAM pair. It provides an instruction memory (read-only to the core) and a data memory (byte-lane writes) with separate ports, so Harvard isolation is preserved. Read latency is configurable, reads use a request/grant and rvalid handshake, and the data port reports out-of-range accesses. A load-mode FSM lets a boot loader rewrite instruction memory safely while core fetches are held off.

---
 rtl/harvard_mem_subsys.sv | 217 +++++++++++++++++++++
 tb/tb_harvard_mem_subsys.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harvard_mem_subsys.sv
// -----------------------------------------------------------------------------
// harvard_mem_subsys
//   Split instruction / data memory pair with independent ports.
//   - IMEM: read-only to the core through a req/gnt + rvalid fetch port; it can
//     only be rewritten by a boot loader through the load port while a small
//     FSM (RUN -> DRAIN -> LOAD) holds fetches off.
//   - DMEM: byte-lane writable, always granted, reports out-of-range accesses.
//   Both read paths have RD_LAT cycles of latency after the accept edge
//   (1, or 2 with an extra output register).
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_imem_req/addr               fetch request and word address
//   o_imem_gnt                    combinational grant
//   o_imem_rdata/rvalid           fetch data and 1-cycle valid pulse
//   i_dmem_req/we/addr/wdata      data access; we == 0 means read
//   o_dmem_rdata/rvalid           read data and valid pulse (reads only)
//   o_dmem_err                    out-of-range pulse, aligned with rvalid slot
//   i_ld_en/we/addr/wdata         boot-loader interface into IMEM
//   o_ld_ready                    FSM is in LOAD, writes are honoured
//   o_busy                        FSM is in DRAIN or LOAD
// -----------------------------------------------------------------------------
module harvard_mem_subsys #(
  parameter int          DATA_W     = 16,
  parameter int          IADDR_W    = 9,
  parameter int          DADDR_W    = 9,
  parameter int unsigned DMEM_DEPTH = 512,
  parameter int          RD_LAT     = 1,
  parameter              IMEM_INIT  = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_imem_req,
  input  logic [IADDR_W-1:0]    i_imem_addr,
  output logic                  o_imem_gnt,
  output logic [DATA_W-1:0]     o_imem_rdata,
  output logic                  o_imem_rvalid,
  input  logic                  i_dmem_req,
  input  logic [DATA_W/8-1:0]   i_dmem_we,
  input  logic [DADDR_W-1:0]    i_dmem_addr,
  input  logic [DATA_W-1:0]     i_dmem_wdata,
  output logic [DATA_W-1:0]     o_dmem_rdata,
  output logic                  o_dmem_rvalid,
  output logic                  o_dmem_err,
  input  logic                  i_ld_en,
  input  logic                  i_ld_we,
  input  logic [IADDR_W-1:0]    i_ld_addr,
  input  logic [DATA_W-1:0]     i_ld_wdata,
  output logic                  o_ld_ready,
  output logic                  o_busy
);

  localparam int NB     = DATA_W / 8;
  localparam int IDEPTH = 2 ** IADDR_W;
  // One extra bit so DMEM_DEPTH == 2**DADDR_W is representable.
  localparam logic [DADDR_W:0] DEPTH_L    = (DADDR_W + 1)'(DMEM_DEPTH);
  // Drain lasts RD_LAT cycles; the counter value on the final drain cycle.
  localparam logic             DRAIN_LAST = 1'(RD_LAT - 1);

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end
  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] imem [IDEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // Power-up image of the instruction memory: all zero.
  initial begin
    for (int i = 0; i < IDEPTH; i++) imem[i] = '0;
  end

  // ---------------------------------------------------------------------------
  // Load-mode FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  state_e state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;
  logic   imem_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 1'b0;
    o_imem_gnt  = 1'b0;
    o_ld_ready  = 1'b0;
    o_busy      = 1'b1;
    imem_we     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        o_busy = 1'b0;
        // The grant is withheld in the cycle we leave RUN so the drain only
        // has to cover requests accepted before it.
        if (i_ld_en) state_d    = ST_DRAIN;
        else         o_imem_gnt = i_imem_req;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d     = i_ld_en ? ST_LOAD : ST_RUN;
        else                           drain_cnt_d = drain_cnt_q + 1'b1;
      end
      ST_LOAD: begin
        o_ld_ready = 1'b1;
        imem_we    = i_ld_we;
        if (!i_ld_en) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write ports
  // ---------------------------------------------------------------------------
  logic d_in_range;
  logic d_rd;

  assign d_in_range = ({1'b0, i_dmem_addr} < DEPTH_L);
  assign d_rd       = i_dmem_req && (i_dmem_we == '0);

  // NOTE: memory arrays have no reset; contents survive i_rst, which is also
  // what lets an interrupted load keep the words already written.
  always_ff @(posedge i_clk) begin
    if (imem_we) imem[i_ld_addr] <= i_ld_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_dmem_req && d_in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (i_dmem_we[k]) dmem[i_dmem_addr][8*k +: 8] <= i_dmem_wdata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines, first stage (array read register)
  // ---------------------------------------------------------------------------
  logic              f_vld1_q;
  logic [DATA_W-1:0] f_dat1_q;
  logic              d_vld1_q;
  logic              d_err1_q;
  logic [DATA_W-1:0] d_dat1_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_vld1_q <= 1'b0;
      f_dat1_q <= '0;
      d_vld1_q <= 1'b0;
      d_err1_q <= 1'b0;
      d_dat1_q <= '0;
    end else begin
      f_vld1_q <= o_imem_gnt;
      if (o_imem_gnt) f_dat1_q <= imem[i_imem_addr];
      d_vld1_q <= d_rd;
      d_err1_q <= i_dmem_req && !d_in_range;
      // Data registers only move on a read so rdata holds between pulses.
      if (d_rd) d_dat1_q <= d_in_range ? dmem[i_dmem_addr] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register stage
  // ---------------------------------------------------------------------------
  if (RD_LAT == 2) begin : g_lat2
    logic              f_vld2_q;
    logic [DATA_W-1:0] f_dat2_q;
    logic              d_vld2_q;
    logic              d_err2_q;
    logic [DATA_W-1:0] d_dat2_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        f_vld2_q <= 1'b0;
        f_dat2_q <= '0;
        d_vld2_q <= 1'b0;
        d_err2_q <= 1'b0;
        d_dat2_q <= '0;
      end else begin
        f_vld2_q <= f_vld1_q;
        if (f_vld1_q) f_dat2_q <= f_dat1_q;
        d_vld2_q <= d_vld1_q;
        d_err2_q <= d_err1_q;
        if (d_vld1_q) d_dat2_q <= d_dat1_q;
      end
    end

    assign o_imem_rvalid = f_vld2_q;
    assign o_imem_rdata  = f_dat2_q;
    assign o_dmem_rvalid = d_vld2_q;
    assign o_dmem_err    = d_err2_q;
    assign o_dmem_rdata  = d_dat2_q;
  end else begin : g_lat1
    assign o_imem_rvalid = f_vld1_q;
    assign o_imem_rdata  = f_dat1_q;
    assign o_dmem_rvalid = d_vld1_q;
    assign o_dmem_err    = d_err1_q;
    assign o_dmem_rdata  = d_dat1_q;
  end

endmodule

// File: tb/tb_harvard_mem_subsys.sv
// -----------------------------------------------------------------------------
// tb_harvard_mem_subsys
//   Two instances (RD_LAT = 1 and 2, DMEM_DEPTH = 300) share one stimulus
//   stream. Stimulus tasks consult an array-based reference model and push the
//   expected responses (data, error flag, arrival cycle) into per-instance
//   queues; a negedge monitor pops and compares whenever an instance presents
//   rvalid or err, and flags late or spurious responses.
// -----------------------------------------------------------------------------
module tb_harvard_mem_subsys;

  localparam int DEPTH = 300;

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] due;
  } fexp_t;

  typedef struct packed {
    logic        is_rd;
    logic        err;
    logic [15:0] data;
    logic [31:0] due;
  } dexp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        dmem_req;
  logic [1:0]  dmem_we;
  logic [8:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        ld_en;
  logic        ld_we;
  logic [8:0]  ld_addr;
  logic [15:0] ld_wdata;

  logic        imem_gnt    [2];
  logic [15:0] imem_rdata  [2];
  logic        imem_rvalid [2];
  logic [15:0] dmem_rdata  [2];
  logic        dmem_rvalid [2];
  logic        dmem_err    [2];
  logic        ld_ready    [2];
  logic        busy        [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    harvard_mem_subsys #(
      .DATA_W    (16),
      .IADDR_W   (9),
      .DADDR_W   (9),
      .DMEM_DEPTH(DEPTH),
      .RD_LAT    (g + 1),
      .IMEM_INIT ("")
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_imem_req   (imem_req),
      .i_imem_addr  (imem_addr),
      .o_imem_gnt   (imem_gnt[g]),
      .o_imem_rdata (imem_rdata[g]),
      .o_imem_rvalid(imem_rvalid[g]),
      .i_dmem_req   (dmem_req),
      .i_dmem_we    (dmem_we),
      .i_dmem_addr  (dmem_addr),
      .i_dmem_wdata (dmem_wdata),
      .o_dmem_rdata (dmem_rdata[g]),
      .o_dmem_rvalid(dmem_rvalid[g]),
      .o_dmem_err   (dmem_err[g]),
      .i_ld_en      (ld_en),
      .i_ld_we      (ld_we),
      .i_ld_addr    (ld_addr),
      .i_ld_wdata   (ld_wdata),
      .o_ld_ready   (ld_ready[g]),
      .o_busy       (busy[g])
    );
  end

  // Reference model and scoreboard state
  logic [15:0] im [512];
  logic [15:0] dm [DEPTH];
  fexp_t       fq [2][$];
  dexp_t       dq [2][$];
  logic [15:0] f_last [2];
  logic [15:0] d_last [2];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every response against the head of its queue
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        fexp_t fe;
        dexp_t de;
        if (imem_rvalid[k]) begin
          if (fq[k].size() == 0) check($sformatf("imem%0d spurious rvalid", k), 1, 0);
          else begin
            fe = fq[k].pop_front();
            check($sformatf("imem%0d rdata", k), imem_rdata[k], fe.data);
            check($sformatf("imem%0d latency", k), cyc, fe.due);
            f_last[k] = fe.data;
          end
        end else begin
          check($sformatf("imem%0d rdata hold", k), imem_rdata[k], f_last[k]);
        end
        if (fq[k].size() != 0 && int'(fq[k][0].due) <= cyc) begin
          fe = fq[k].pop_front();
          check($sformatf("imem%0d missing rvalid due %0d", k, fe.due), 0, 1);
        end

        if (dmem_rvalid[k] || dmem_err[k]) begin
          if (dq[k].size() == 0) check($sformatf("dmem%0d spurious response", k), 1, 0);
          else begin
            de = dq[k].pop_front();
            check($sformatf("dmem%0d rvalid", k), dmem_rvalid[k], de.is_rd);
            check($sformatf("dmem%0d err", k), dmem_err[k], de.err);
            check($sformatf("dmem%0d latency", k), cyc, de.due);
            if (de.is_rd) begin
              check($sformatf("dmem%0d rdata", k), dmem_rdata[k], de.data);
              d_last[k] = de.data;
            end
          end
        end
        if (!dmem_rvalid[k]) check($sformatf("dmem%0d rdata hold", k), dmem_rdata[k], d_last[k]);
        if (dq[k].size() != 0 && int'(dq[k][0].due) <= cyc) begin
          de = dq[k].pop_front();
          check($sformatf("dmem%0d missing response due %0d", k, de.due), 0, 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = '0;
    ld_we    = 1'b0;
  endtask

  task automatic issue_fetch(input logic [8:0] addr, input bit exp_gnt);
    imem_req  = 1'b1;
    imem_addr = addr;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("imem%0d gnt", k), imem_gnt[k], exp_gnt);
      if (exp_gnt) fq[k].push_back('{data: im[addr], due: 32'(cyc + k + 1)});
    end
  endtask

  task automatic issue_dmem(input logic [1:0] we, input logic [8:0] addr, input logic [15:0] wdata);
    bit          inr;
    logic [15:0] rd;
    dmem_req   = 1'b1;
    dmem_we    = we;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    inr        = (int'(addr) < DEPTH);
    if (we == 2'b00) begin
      rd = inr ? dm[addr] : 16'h0000;
      for (int k = 0; k < 2; k++)
        dq[k].push_back('{is_rd: 1'b1, err: !inr, data: rd, due: 32'(cyc + k + 1)});
    end else if (inr) begin
      for (int b = 0; b < 2; b++)
        if (we[b]) dm[addr][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      for (int k = 0; k < 2; k++)
        dq[k].push_back('{is_rd: 1'b0, err: 1'b1, data: 16'h0000, due: 32'(cyc + k + 1)});
    end
  endtask

  // Raise i_ld_en and follow both instances through DRAIN into LOAD. Step e is
  // the number of cycles since i_ld_en was raised: busy from step 1, ready
  // once RD_LAT drain cycles have passed.
  task automatic enter_load(input bit with_fetch);
    next_cycle();
    ld_en = 1'b1;
    if (with_fetch) issue_fetch(9'($urandom_range(0, 511)), 1'b0);
    for (int e = 0; e < 4; e++) begin
      if (e != 0) begin
        next_cycle();
        if (with_fetch) begin
          imem_req = 1'b1;
          #1;
          for (int k = 0; k < 2; k++) check($sformatf("imem%0d gnt held off", k), imem_gnt[k], 0);
        end
      end
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ld%0d ready step %0d", k, e), ld_ready[k], (e >= k + 2));
        check($sformatf("ld%0d busy step %0d", k, e), busy[k], (e >= 1));
      end
    end
  endtask

  task automatic load_word(input logic [8:0] addr, input logic [15:0] data);
    next_cycle();
    ld_we    = 1'b1;
    ld_addr  = addr;
    ld_wdata = data;
    im[addr] = data;
  endtask

  task automatic exit_load();
    next_cycle();
    ld_en = 1'b0;
    for (int k = 0; k < 2; k++) check($sformatf("ld%0d ready on exit", k), ld_ready[k], 1);
  endtask

  task automatic check_quiet(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s imem%0d rvalid", tag, k), imem_rvalid[k], 0);
      check($sformatf("%s dmem%0d rvalid", tag, k), dmem_rvalid[k], 0);
      check($sformatf("%s dmem%0d err", tag, k), dmem_err[k], 0);
      check($sformatf("%s ld%0d ready", tag, k), ld_ready[k], 0);
      check($sformatf("%s busy%0d", tag, k), busy[k], 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    ld_en      = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    for (int k = 0; k < 2; k++) begin
      f_last[k] = '0;
      d_last[k] = '0;
    end

    repeat (3) @(posedge clk);
    #2;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    mon_en = 1'b1;

    // Fill IMEM through the loader and DMEM through the data port so every
    // later read has a known reference value.
    enter_load(1'b0);
    for (int a = 0; a < 512; a++) load_word(9'(a), 16'($urandom));
    exit_load();
    for (int a = 0; a < DEPTH; a++) begin
      next_cycle();
      issue_dmem(2'b11, 9'(a), 16'($urandom));
    end

    // Isolation: a DMEM write to the same address must not reach IMEM.
    next_cycle(); issue_fetch(9'd128, 1'b1);
    next_cycle(); issue_dmem(2'b11, 9'd128, 16'hABCD);
    next_cycle(); issue_dmem(2'b00, 9'd128, 16'h0000);
    next_cycle(); issue_fetch(9'd128, 1'b1);

    // Byte lanes at address 5, each read directly after the write.
    next_cycle(); issue_dmem(2'b11, 9'd5, 16'h1234);
    next_cycle(); issue_dmem(2'b01, 9'd5, 16'hABCD);
    next_cycle(); issue_dmem(2'b00, 9'd5, 16'h0000);
    next_cycle(); issue_dmem(2'b10, 9'd5, 16'hEEFF);
    next_cycle(); issue_dmem(2'b00, 9'd5, 16'h0000);

    // Load mode with three fetches in flight; DMEM keeps working in LOAD.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      issue_fetch(9'(40 + i), 1'b1);
    end
    enter_load(1'b1);
    load_word(9'd7, 16'hBEEF);
    issue_dmem(2'b00, 9'd5, 16'h0000);
    exit_load();
    next_cycle(); issue_fetch(9'd7, 1'b1);

    // Loader strobe outside LOAD must leave IMEM untouched.
    next_cycle();
    ld_we = 1'b1; ld_addr = 9'd9; ld_wdata = 16'h1111;
    next_cycle(); issue_fetch(9'd9, 1'b1);

    // Range boundary.
    next_cycle(); issue_dmem(2'b11, 9'd300, 16'h5555);
    next_cycle(); issue_dmem(2'b00, 9'd300, 16'h0000);
    next_cycle(); issue_dmem(2'b00, 9'd299, 16'h0000);
    next_cycle(); issue_dmem(2'b00, 9'd511, 16'h0000);

    // Concurrency: both ports every cycle, reads first, then mixed traffic
    // including stray loader strobes.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      issue_fetch(9'($urandom_range(0, 511)), 1'b1);
      issue_dmem(2'b00, 9'($urandom_range(0, DEPTH - 1)), 16'h0000);
    end
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      if ($urandom_range(0, 7) == 0) begin
        ld_we = 1'b1; ld_addr = 9'($urandom); ld_wdata = 16'($urandom);
      end
      issue_fetch(9'($urandom_range(0, 511)), 1'b1);
      issue_dmem(2'($urandom_range(0, 3)), 9'($urandom_range(0, DEPTH + 40)), 16'($urandom));
    end

    // Asynchronous reset in LOAD with a read in flight.
    repeat (4) next_cycle();
    enter_load(1'b0);
    load_word(9'd20, 16'h5A5A);
    next_cycle();
    issue_dmem(2'b00, 9'd3, 16'h0000);
    next_cycle();
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    ld_en  = 1'b0;
    #1;
    check_quiet("async reset");
    for (int k = 0; k < 2; k++) begin
      fq[k].delete();
      dq[k].delete();
      f_last[k] = '0;
      d_last[k] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    repeat (3) next_cycle();
    for (int k = 0; k < 2; k++) check($sformatf("busy%0d after reset", k), busy[k], 0);
    issue_fetch(9'd20, 1'b1);

    repeat (6) next_cycle();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("imem%0d queue drained", k), fq[k].size(), 0);
      check($sformatf("dmem%0d queue drained", k), dq[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
